// File: rtl/btn_color_sel.sv
// Button conditioner for the RGB LED path: synchronise, debounce and edge-detect
// raw push-buttons, then latch a sticky one-hot colour selection (red > green > blue).
module btn_color_sel #(
  parameter int unsigned N_BTN     = 3,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DB_CNT_W  = 20,
  parameter int unsigned RESET_SEL = 2
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn_raw,
  output logic [N_BTN-1:0] o_btn_sel,
  output logic [N_BTN-1:0] o_btn_db,
  output logic [N_BTN-1:0] o_press,
  output logic             o_sel_change
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST  = DB_CNT_W'(DB_CYCLES - 1);
  localparam logic [N_BTN-1:0]    SEL_RESET = N_BTN'(1) << RESET_SEL;

  logic [N_BTN-1:0]               sync1;
  logic [N_BTN-1:0]               sync2;
  logic [N_BTN-1:0][DB_CNT_W-1:0] cnt;
  logic [N_BTN-1:0][DB_CNT_W-1:0] cnt_next;
  logic [N_BTN-1:0]               db_next;
  logic [N_BTN-1:0]               sel_next;

  // Per-bit debounce: count while synced level differs, accept on the last count.
  always_comb begin
    cnt_next = '0;
    db_next  = o_btn_db;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2[i] != o_btn_db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  // Highest pressed index wins; no press keeps the current selection.
  always_comb begin
    sel_next = o_btn_sel;
    for (int i = 0; i < N_BTN; i++) begin
      if (o_press[i]) begin
        sel_next    = '0;
        sel_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      sync1        <= '0;
      sync2        <= '0;
      cnt          <= '0;
      o_btn_db     <= '0;
      o_press      <= '0;
      o_btn_sel    <= SEL_RESET;
      o_sel_change <= 1'b0;
    end else begin
      sync1        <= i_btn_raw;
      sync2        <= sync1;
      cnt          <= cnt_next;
      o_btn_db     <= db_next;
      o_press      <= db_next & ~o_btn_db;
      o_btn_sel    <= sel_next;
      o_sel_change <= (sel_next != o_btn_sel);
    end
  end

endmodule

// File: tb/tb_btn_color_sel.sv
// Directed bench for btn_color_sel with a short debounce window (DB_CYCLES=4).
module tb_btn_color_sel;

  localparam int unsigned N_BTN = 3;

  logic             clk;
  logic             i_reset;
  logic [N_BTN-1:0] i_btn_raw;
  logic [N_BTN-1:0] o_btn_sel;
  logic [N_BTN-1:0] o_btn_db;
  logic [N_BTN-1:0] o_press;
  logic             o_sel_change;

  int total;
  int bad;
  int npress;

  btn_color_sel #(
    .N_BTN    (N_BTN),
    .DB_CYCLES(4),
    .DB_CNT_W (3),
    .RESET_SEL(2)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_btn_raw   (i_btn_raw),
    .o_btn_sel   (o_btn_sel),
    .o_btn_db    (o_btn_db),
    .o_press     (o_press),
    .o_sel_change(o_sel_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] sel, input logic [2:0] db,
                            input logic [2:0] press, input logic chg);
    check({tag, ".sel"},   32'(o_btn_sel),    32'(sel));
    check({tag, ".db"},    32'(o_btn_db),     32'(db));
    check({tag, ".press"}, 32'(o_press),      32'(press));
    check({tag, ".chg"},   32'(o_sel_change), 32'(chg));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    i_reset   = 1'b1;
    i_btn_raw = '0;
    tick();
    check_outs("reset", 3'b100, 3'b000, 3'b000, 1'b0);
    i_reset = 1'b0;
    repeat (3) tick();
    check_outs("idle", 3'b100, 3'b000, 3'b000, 1'b0);

    // Clean press of green
    i_btn_raw = 3'b010;
    repeat (5) tick();
    check_outs("clean_e5", 3'b100, 3'b000, 3'b000, 1'b0);
    tick();
    check_outs("clean_e6", 3'b100, 3'b010, 3'b010, 1'b0);
    tick();
    check_outs("clean_e7", 3'b010, 3'b010, 3'b000, 1'b1);
    tick();
    check_outs("clean_e8", 3'b010, 3'b010, 3'b000, 1'b0);
    npress = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (o_press != 3'b000 || o_sel_change) npress++;
    end
    check("hold_no_pulse", 32'(npress), 32'd0);
    check("hold_sel", 32'(o_btn_sel), 32'(3'b010));

    // Asynchronous reset mid-simulation, checked before any clock edge
    i_btn_raw = 3'b000;
    #2;
    i_reset = 1'b1;
    #1;
    check_outs("async_reset", 3'b100, 3'b000, 3'b000, 1'b0);
    tick();
    i_reset = 1'b0;
    repeat (3) tick();
    check_outs("post_reset", 3'b100, 3'b000, 3'b000, 1'b0);

    // Bounce rejection on blue: 1-, 2-, 3-cycle glitches
    for (int g = 1; g <= 3; g++) begin
      i_btn_raw = 3'b001;
      for (int c = 0; c < g; c++) begin
        tick();
        check_outs("bounce_hi", 3'b100, 3'b000, 3'b000, 1'b0);
      end
      i_btn_raw = 3'b000;
      for (int c = 0; c < 3; c++) begin
        tick();
        check_outs("bounce_lo", 3'b100, 3'b000, 3'b000, 1'b0);
      end
    end
    repeat (3) begin
      tick();
      check_outs("bounce_flush", 3'b100, 3'b000, 3'b000, 1'b0);
    end
    i_btn_raw = 3'b001;
    repeat (6) tick();
    check_outs("blue_e6", 3'b100, 3'b001, 3'b001, 1'b0);
    tick();
    check_outs("blue_e7", 3'b001, 3'b001, 3'b000, 1'b1);
    repeat (3) tick();
    check_outs("blue_e10", 3'b001, 3'b001, 3'b000, 1'b0);

    // Release keeps the selection
    i_btn_raw = 3'b000;
    repeat (5) tick();
    check("rel_e5_db", 32'(o_btn_db), 32'(3'b001));
    tick();
    check_outs("rel_e6", 3'b001, 3'b000, 3'b000, 1'b0);
    repeat (4) tick();
    check_outs("rel_e10", 3'b001, 3'b000, 3'b000, 1'b0);

    // Reset during debounce of red, button kept held through reset
    i_btn_raw = 3'b100;
    repeat (2) tick();
    #2;
    i_reset = 1'b1;
    #1;
    check_outs("mid_db_reset", 3'b100, 3'b000, 3'b000, 1'b0);
    tick();
    i_reset = 1'b0;
    repeat (5) tick();
    check_outs("red_e5", 3'b100, 3'b000, 3'b000, 1'b0);
    tick();
    check_outs("red_e6", 3'b100, 3'b100, 3'b100, 1'b0);
    tick();
    check_outs("red_e7", 3'b100, 3'b100, 3'b000, 1'b0);
    i_btn_raw = 3'b000;
    repeat (8) tick();
    check_outs("red_rel", 3'b100, 3'b000, 3'b000, 1'b0);

    // Simultaneous green+blue: green wins
    i_btn_raw = 3'b011;
    repeat (6) tick();
    check_outs("simul_e6", 3'b100, 3'b011, 3'b011, 1'b0);
    tick();
    check_outs("simul_e7", 3'b010, 3'b011, 3'b000, 1'b1);
    tick();
    check_outs("simul_e8", 3'b010, 3'b011, 3'b000, 1'b0);

    // Release and re-press the selected colour
    i_btn_raw = 3'b000;
    repeat (8) tick();
    check_outs("repress_idle", 3'b010, 3'b000, 3'b000, 1'b0);
    i_btn_raw = 3'b010;
    npress = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_press[1]) npress++;
      check("repress_chg", 32'(o_sel_change), 32'd0);
      check("repress_sel", 32'(o_btn_sel), 32'(3'b010));
    end
    check("repress_pulses", 32'(npress), 32'd1);
    check("repress_db", 32'(o_btn_db), 32'(3'b010));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
